// File: rtl/instr_executor_pkg.sv
// Shared types and constants for the instruction executor and its divider.
package instr_executor_pkg;

    localparam int NUM_ENTRIES = 32;
    localparam int DIV_CYCLES  = 32;
    localparam int ADDR_W      = $clog2(NUM_ENTRIES);
    localparam int OPND_W      = 32;
    localparam int RES_W       = 64;

    typedef logic [ADDR_W-1:0]        address_t;
    typedef logic signed [OPND_W-1:0] operand_t;
    typedef logic signed [RES_W-1:0]  operand_r;

    // Encodings 8..15 are not defined and are reported as errors.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        OUTPUT
    } exec_state_t;

    // Sign-extend a 32-bit operand to the 64-bit result width.
    function automatic operand_r sext(input operand_t v);
        return {{(RES_W-OPND_W){v[OPND_W-1]}}, v};
    endfunction

    // Unsigned magnitude; -2^31 maps to 2^31, which still fits in 32 unsigned bits.
    function automatic logic [OPND_W-1:0] magnitude(input operand_t v);
        return v[OPND_W-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/instr_executor_if.sv
// Result handshake and payload bus between the executor and its consumer.
interface instr_executor_if;
    import instr_executor_pkg::*;

    logic     res_valid;
    logic     res_ready;
    address_t res_addr;
    opcode_t  res_opc;
    operand_r res_value;
    logic     res_err;

    modport master (
        output res_valid,
        output res_addr,
        output res_opc,
        output res_value,
        output res_err,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_addr,
        input  res_opc,
        input  res_value,
        input  res_err,
        output res_ready
    );

endinterface

// File: rtl/instr_executor_divider.sv
// Iterative signed 32/32 divider: restoring division on magnitudes, one
// quotient bit per cycle, signs applied to the registered magnitudes.
module instr_divider
    import instr_executor_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     start,
    input  operand_t dividend,
    input  operand_t divisor,
    output logic     done,
    output operand_r quotient,
    output operand_r remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic              running_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [OPND_W-1:0] rem_reg;
    logic [OPND_W-1:0] quo_reg;
    logic [OPND_W-1:0] dsr_reg;
    logic              q_neg_reg;
    logic              r_neg_reg;

    logic [OPND_W:0]   rem_shift;
    logic [OPND_W:0]   trial;
    logic [OPND_W-1:0] rem_next;
    logic [OPND_W-1:0] quo_next;
    operand_r          q_mag;
    operand_r          r_mag;

    // done marks the cycle whose clock edge performs the final iteration.
    assign done = running_reg && (cnt_reg == CNT_W'(DIV_CYCLES - 1));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[OPND_W-1]};
        trial     = rem_shift - {1'b0, dsr_reg};
        if (trial[OPND_W]) begin
            rem_next = rem_shift[OPND_W-1:0];
            quo_next = {quo_reg[OPND_W-2:0], 1'b0};
        end else begin
            rem_next = trial[OPND_W-1:0];
            quo_next = {quo_reg[OPND_W-2:0], 1'b1};
        end
    end

    // Signed fix-up: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        q_mag     = operand_r'({{(RES_W-OPND_W){1'b0}}, quo_reg});
        r_mag     = operand_r'({{(RES_W-OPND_W){1'b0}}, rem_reg});
        quotient  = q_neg_reg ? -q_mag : q_mag;
        remainder = r_neg_reg ? -r_mag : r_mag;
    end

    // Load operands on start, then iterate for DIV_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dsr_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= magnitude(dividend);
            dsr_reg     <= magnitude(divisor);
            q_neg_reg   <= dividend[OPND_W-1] ^ divisor[OPND_W-1];
            r_neg_reg   <= dividend[OPND_W-1];
        end else if (running_reg) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                running_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_executor.sv
// Scans a run of instruction-register slots, executes each instruction and
// presents one result per slot on a valid/ready bus.
module instr_executor
    import instr_executor_pkg::*;
#(
    parameter int NUM_ENTRIES = instr_executor_pkg::NUM_ENTRIES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  address_t                  first_addr,
    input  logic [5:0]                count,
    output address_t                  read_pointer,
    input  instruction_t              instruction_word,
    instr_executor_if.master          res,
    output logic                      busy,
    output logic                      done
);

    exec_state_t state_reg;
    address_t    read_pointer_reg;
    logic [5:0]  remaining_reg;
    operand_t    op_a_reg;
    operand_t    op_b_reg;
    logic        res_valid_reg;
    address_t    res_addr_reg;
    opcode_t     res_opc_reg;
    operand_r    res_value_reg;
    logic        res_err_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        div_start;
    logic        div_done;
    operand_r    div_quotient;
    operand_r    div_remainder;
    operand_r    result_next;
    logic        result_err_next;
    address_t    ptr_inc;
    logic [5:0]  count_sat;

    assign read_pointer  = read_pointer_reg;
    assign res.res_valid = res_valid_reg;
    assign res.res_addr  = res_addr_reg;
    assign res.res_opc   = res_opc_reg;
    assign res.res_value = res_value_reg;
    assign res.res_err   = res_err_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

    assign ptr_inc   = (read_pointer_reg == address_t'(NUM_ENTRIES - 1)) ? '0 : read_pointer_reg + 1'b1;
    assign count_sat = (count > 6'(NUM_ENTRIES)) ? 6'(NUM_ENTRIES) : count;

    // A divide is launched straight from the fetched word; divide-by-zero never enters EXEC.
    assign div_start = (state_reg == FETCH)
                    && ((instruction_word.opc == DIV) || (instruction_word.opc == MOD))
                    && (instruction_word.op_b != '0);

    instr_divider u_divider (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (instruction_word.op_a),
        .divisor   (instruction_word.op_b),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Result selection from the latched operands (and divider outputs for DIV/MOD).
    always_comb begin
        result_next     = '0;
        result_err_next = 1'b0;
        case (res_opc_reg)
            ZERO:  result_next = '0;
            PASSA: result_next = sext(op_a_reg);
            PASSB: result_next = sext(op_b_reg);
            ADD:   result_next = sext(op_a_reg) + sext(op_b_reg);
            SUB:   result_next = sext(op_a_reg) - sext(op_b_reg);
            MULT:  result_next = sext(op_a_reg) * sext(op_b_reg);
            DIV: begin
                if (op_b_reg == '0) result_err_next = 1'b1;
                else                result_next     = div_quotient;
            end
            MOD: begin
                if (op_b_reg == '0) result_err_next = 1'b1;
                else                result_next     = div_remainder;
            end
            default: result_err_next = 1'b1;
        endcase
    end

    // Scan FSM with registered outputs: IDLE -> FETCH -> (EXEC) -> OUTPUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            read_pointer_reg <= '0;
            remaining_reg    <= '0;
            op_a_reg         <= '0;
            op_b_reg         <= '0;
            res_valid_reg    <= 1'b0;
            res_addr_reg     <= '0;
            res_opc_reg      <= ZERO;
            res_value_reg    <= '0;
            res_err_reg      <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && (count != 6'd0)) begin
                        read_pointer_reg <= first_addr;
                        remaining_reg    <= count_sat;
                        busy_reg         <= 1'b1;
                        state_reg        <= FETCH;
                    end
                end
                FETCH: begin
                    res_opc_reg  <= instruction_word.opc;
                    res_addr_reg <= read_pointer_reg;
                    op_a_reg     <= instruction_word.op_a;
                    op_b_reg     <= instruction_word.op_b;
                    state_reg    <= div_start ? EXEC : OUTPUT;
                end
                EXEC: begin
                    if (div_done) begin
                        state_reg <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (!res_valid_reg) begin
                        res_valid_reg <= 1'b1;
                        res_value_reg <= result_next;
                        res_err_reg   <= result_err_next;
                    end else if (res.res_ready) begin
                        res_valid_reg <= 1'b0;
                        if (remaining_reg > 6'd1) begin
                            remaining_reg    <= remaining_reg - 1'b1;
                            read_pointer_reg <= ptr_inc;
                            state_reg        <= FETCH;
                        end else begin
                            remaining_reg <= '0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_executor.sv
// Scoreboard bench for instr_executor: stimulus pushes expected results,
// a negedge monitor pops and compares them as results appear.
module tb_instr_executor;
    import instr_executor_pkg::*;

    typedef struct {
        address_t addr;
        opcode_t  opc;
        operand_r value;
        logic     err;
        int       lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         done;

    instr_executor_if bus();

    instruction_t mem [NUM_ENTRIES];
    exp_t         exp_q [$];
    exp_t         mon_e;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   trig_cyc = 0;
    int   hs_cnt = 0;
    int   exp_hs = 0;
    int   done_cnt = 0;
    logic prev_valid = 1'b0;
    logic done_pending = 1'b0;

    localparam operand_t MIN_INT = 32'sh8000_0000;

    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_executor #(.NUM_ENTRIES(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res              (bus),
        .busy             (busy),
        .done             (done)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic set_slot(input int a, input opcode_t opc, input operand_t x, input operand_t y);
        mem[a] = {opc, x, y};
    endtask

    task automatic push(input address_t a, input opcode_t opc, input operand_r v, input logic e, input int lat);
        exp_t t;
        t.addr = a; t.opc = opc; t.value = v; t.err = e; t.lat = lat;
        exp_q.push_back(t);
    endtask

    task automatic do_start(input address_t fa, input logic [5:0] cnt, input int nhs, input int hold);
        @(posedge clk); #1;
        first_addr = fa;
        count      = cnt;
        start      = 1'b1;
        trig_cyc   = cyc + 1;
        hs_cnt     = 0;
        exp_hs     = nhs;
        repeat (hold) begin @(posedge clk); #1; end
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while ((done_cnt == base) && (n < budget)) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_read_pointer"}, 64'(read_pointer), 64'd0);
        chk({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_res_addr"}, 64'(bus.res_addr), 64'd0);
        chk({tag, "_res_opc"}, 64'(bus.res_opc), 64'(ZERO));
        chk({tag, "_res_value"}, bus.res_value, 64'd0);
        chk({tag, "_res_err"}, 64'(bus.res_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // Monitor: compare each result when res_valid rises, track handshakes and done.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got addr=%0d value=%0h, expected no result", bus.res_addr, bus.res_value);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("result addr=%0d opc=%0d value=%0d err=%0b latency=%0d",
                             bus.res_addr, bus.res_opc, bus.res_value, bus.res_err, cyc - trig_cyc);
                    chk("res_addr", 64'(bus.res_addr), 64'(mon_e.addr));
                    chk("res_opc", 64'(bus.res_opc), 64'(mon_e.opc));
                    chk("res_value", bus.res_value, mon_e.value);
                    chk("res_err", 64'(bus.res_err), 64'(mon_e.err));
                    chk("latency", 64'(cyc - trig_cyc), 64'(mon_e.lat));
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                hs_cnt++;
                trig_cyc = cyc + 1;
            end
            if (done_pending) begin
                chk("done_width", 64'(done), 64'd0);
                done_pending = 1'b0;
            end
            if (done) begin
                chk("done_after_handshakes", 64'(hs_cnt), 64'(exp_hs));
                chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
                done_cnt++;
                done_pending = 1'b1;
            end
        end
        prev_valid = bus.res_valid;
    end

    // Global time limit so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by 300000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        opcode_t bad_opc;
        bad_opc = opcode_t'(4'd12);
        for (int i = 0; i < NUM_ENTRIES; i++) mem[i] = '0;
        reset_n       = 1'b0;
        start         = 1'b0;
        first_addr    = '0;
        count         = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // count = 0 is ignored
        do_start(5'd0, 6'd0, 0, 1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("count0_busy", 64'(busy), 64'd0);
        end

        // Single ADD, start held for several cycles
        set_slot(0, ADD, 32'sd5, -32'sd7);
        push(5'd0, ADD, -64'sd2, 1'b0, 2);
        do_start(5'd0, 6'd1, 1, 3);
        wait_done(20);

        // Divide signs and the -2^31 / -1 case
        set_slot(3, DIV, 32'sd7, -32'sd2);
        set_slot(4, MOD, 32'sd7, -32'sd2);
        set_slot(5, DIV, MIN_INT, -32'sd1);
        push(5'd3, DIV, -64'sd3, 1'b0, 34);
        push(5'd4, MOD, 64'sd1, 1'b0, 34);
        push(5'd5, DIV, 64'sd2147483648, 1'b0, 34);
        do_start(5'd3, 6'd3, 3, 1);
        wait_done(200);

        // Error cases plus ZERO
        set_slot(7, DIV, 32'sd9, 32'sd0);
        set_slot(8, bad_opc, 32'sd3, 32'sd4);
        set_slot(9, ZERO, 32'sd5, 32'sd6);
        push(5'd7, DIV, 64'sd0, 1'b1, 2);
        push(5'd8, bad_opc, 64'sd0, 1'b1, 2);
        push(5'd9, ZERO, 64'sd0, 1'b0, 2);
        do_start(5'd7, 6'd3, 3, 1);
        wait_done(40);

        // Address wrap and MULT
        set_slot(30, MULT, MIN_INT, MIN_INT);
        set_slot(31, SUB, 32'sd3, 32'sd10);
        set_slot(0, PASSA, 32'sd123, 32'sd9);
        set_slot(1, PASSB, 32'sd4, -32'sd9);
        push(5'd30, MULT, 64'sh4000_0000_0000_0000, 1'b0, 2);
        push(5'd31, SUB, -64'sd7, 1'b0, 2);
        push(5'd0, PASSA, 64'sd123, 1'b0, 2);
        push(5'd1, PASSB, -64'sd9, 1'b0, 2);
        do_start(5'd30, 6'd4, 4, 1);
        wait_done(60);

        // Backpressure: result held, pointer frozen
        set_slot(10, ADD, 32'sd100, 32'sd23);
        push(5'd10, ADD, 64'sd123, 1'b0, 2);
        bus.res_ready = 1'b0;
        do_start(5'd10, 6'd1, 1, 1);
        for (int n = 0; (n < 10) && !bus.res_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid_seen", 64'(bus.res_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_value", bus.res_value, 64'sd123);
            chk("bp_addr", 64'(bus.res_addr), 64'd10);
            chk("bp_read_pointer", 64'(read_pointer), 64'd10);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        bus.res_ready = 1'b1;
        wait_done(20);

        // Reset in the middle of EXEC
        set_slot(12, DIV, 32'sd1000, 32'sd7);
        push(5'd12, DIV, 64'sd142, 1'b0, 34);
        do_start(5'd12, 6'd1, 1, 1);
        repeat (10) begin @(posedge clk); #1; end
        chk("midexec_busy", 64'(busy), 64'd1);
        chk("midexec_valid", 64'(bus.res_valid), 64'd0);
        reset_n = 1'b0;
        #1;
        check_reset("midreset");
        exp_q.delete();
        exp_hs = 0;
        hs_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_slot(13, ADD, 32'sd1, 32'sd1);
        push(5'd13, ADD, 64'sd2, 1'b0, 2);
        do_start(5'd13, 6'd1, 1, 1);
        wait_done(20);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_executor.md
INSTR_EXECUTOR -- requirements
Module: instr_executor

Interface
REQ-001 The module SHALL have parameter NUM_ENTRIES, default 32, the number of instruction-register slots; it SHALL equal 2**width(address_t).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: begins a scan; sampled only in IDLE.
REQ-005 The module SHALL have port first_addr, input, address_t: first slot of the scan.
REQ-006 The module SHALL have port count, input, 6 bits: number of slots to execute.
REQ-007 The module SHALL have port read_pointer, output, address_t: slot address driven to the instruction register.
REQ-008 The module SHALL have port instruction_word, input, instruction_t: combinational read data for read_pointer.
REQ-009 The module SHALL have ports res_valid (output, 1) and res_ready (input, 1): the result handshake.
REQ-010 The module SHALL have ports res_addr (output, address_t), res_opc (output, opcode_t), res_value (output, operand_r) and res_err (output, 1): the result payload.
REQ-011 The module SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle pulse at scan end.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, EXEC and OUTPUT.
- IDLE: start=1 with count!=0 -> FETCH, loading read_pointer with first_addr.
- start with count=0 SHALL be ignored; count>32 SHALL saturate to 32.
REQ-013 FETCH SHALL last one cycle and register opc, op_a, op_b and read_pointer into res_opc/res_addr.
- DIV/MOD with op_b!=0 -> EXEC.
- All other cases -> OUTPUT.
REQ-014 EXEC SHALL last exactly 32 cycles, then -> OUTPUT.
REQ-015 OUTPUT SHALL assert res_valid and hold the payload stable until res_valid&&res_ready.
- On handshake with slots remaining: read_pointer+1, wrapping 31->0, -> FETCH.
- On handshake with no slots remaining: -> IDLE, with done=1 for one cycle.
REQ-016 Latency: start sampled at edge T; res_valid SHALL rise at edge T+2 for single-cycle ops and T+34 for DIV/MOD.
REQ-017 Arithmetic SHALL be signed; operands sign-extend to 64 bits; result per opcode:
- ZERO = 0; PASSA = op_a; PASSB = op_b.
- ADD/SUB: 64-bit exact, never overflow.
- MULT: full 64-bit product.
REQ-018 DIV SHALL truncate toward zero; MOD SHALL take the sign of the dividend; -2^31 / -1 SHALL yield +2^31.
REQ-019 DIV/MOD with op_b=0 SHALL give res_value=0, res_err=1 and skip EXEC.
REQ-020 Opcode encodings 8..15 SHALL give res_value=0 and res_err=1; res_err SHALL be 0 in all other cases.
REQ-021 start asserted while busy SHALL be ignored; start SHALL NOT need to be a pulse.

Reset
REQ-022 reset_n low SHALL, immediately and at any state including mid-EXEC, force IDLE and set outputs as follows:
- read_pointer=0, res_valid=0, res_addr=0, res_opc=ZERO, res_value=0, res_err=0, busy=0, done=0.
- Divider state SHALL be cleared.
REQ-023 The first start after reset release SHALL behave identically to a start from power-up.

Structure
REQ-024 The shared package SHALL contain exec_state_t (the FSM enum) and the constants NUM_ENTRIES=32 and DIV_CYCLES=32, alongside the existing opcode_t, operand_t, operand_r, address_t and instruction_t.
REQ-025 Division SHALL be a separate sub-module, instr_divider: iterative signed 32/32, start/done handshake, DIV_CYCLES cycles, outputs quotient and remainder.

Verification
REQ-026 The bench SHALL cover single ADD: slot 0 = ADD 5,-7; start first_addr=0, count=1 -> res_value=-2, res_err=0, res_addr=0, res_valid at T+2, done after the handshake.
REQ-027 The bench SHALL cover divide signs: slot 3 = DIV 7,-2 and slot 4 = MOD 7,-2 -> -3 and 1, each res_valid 34 cycles after its fetch; plus DIV -2^31,-1 -> 2147483648.
REQ-028 The bench SHALL cover error cases: DIV 9,0 -> res_value 0, res_err 1 at T+2; opcode 12 -> res_value 0, res_err 1.
REQ-029 The bench SHALL cover wrap and MULT: first_addr=30, count=4 -> read_pointer 30,31,0,1; MULT -2^31,-2^31 -> 2^62; done only after the 4th handshake.
REQ-030 The bench SHALL cover backpressure: res_ready low for 5 cycles -> payload stable, read_pointer unchanged, no new FETCH.
REQ-031 The bench SHALL cover mid-operation reset: reset_n low at cycle 10 of EXEC -> all outputs at reset values immediately; a subsequent count=1 ADD 1,1 start -> res_value 2.
